// File: rtl/fetch_pc_sequencer.sv
// Instruction-fetch PC sequencer: one fetch outstanding at a time, predictor query
// on branch accept, and prioritised redirects (restart > interrupt > recover > clean).
module fetch_pc_sequencer #(
    parameter logic [39:0] RESET_PC   = 40'h0,
    parameter logic [39:0] INT_VECTOR = 40'h100,
    parameter logic [39:0] PC_STEP    = 40'd4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [39:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        pd_isBranch,
    input  logic        pd_needPredict,
    input  logic        pd_resolvedTaken,
    input  logic [39:0] pd_target,
    output logic        isBranchJmpCode,
    output logic        qequestBranchPrediction,
    output logic [39:0] qequestJmpAddress,
    input  logic        isJmp,
    input  logic        isRecoverPC,
    input  logic [39:0] recoverAddress,
    input  logic        askClean_FetchMod,
    input  logic        askInterHandle,
    input  logic        askRestartHandle,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [39:0] out_orderAddress,
    output logic [39:0] out_branchJumpAddress,
    output logic        out_branchJumpForecast
);

    // state | meaning
    // REQ   | fetch request at pc outstanding, waiting for mem_ack
    // HOLD  | fetched word presented to parsing stage, waiting for out_ready
    typedef enum logic {REQ, HOLD} state_t;

    state_t      state, state_next;
    logic [39:0] pc, pc_next;
    logic        redirect;
    logic        accept;
    logic        forecast;
    logic [39:0] seq_pc;

    assign redirect = askRestartHandle | askInterHandle | isRecoverPC | askClean_FetchMod;
    assign accept   = (state == REQ) & mem_ack & ~redirect;
    assign seq_pc   = pc + PC_STEP;

    // mem_req is held low while reset is asserted even though state already reads REQ
    assign mem_req  = (state == REQ) & rst;
    assign mem_addr = pc;

    assign isBranchJmpCode         = accept & pd_isBranch;
    assign qequestBranchPrediction = accept & pd_isBranch & pd_needPredict;
    assign qequestJmpAddress       = isBranchJmpCode ? pd_target : 40'h0;

    always_comb begin
        forecast = 1'b0;
        if (pd_isBranch) begin
            forecast = pd_needPredict ? isJmp : pd_resolvedTaken;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        if (askRestartHandle) begin
            pc_next    = RESET_PC;
            state_next = REQ;
        end else if (askInterHandle) begin
            pc_next    = INT_VECTOR;
            state_next = REQ;
        end else if (isRecoverPC) begin
            pc_next    = recoverAddress;
            state_next = REQ;
        end else if (askClean_FetchMod) begin
            state_next = REQ;
        end else begin
            case (state)
                REQ: begin
                    if (mem_ack) begin
                        pc_next    = forecast ? pd_target : seq_pc;
                        state_next = HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_next = REQ;
                    end
                end
                default: state_next = REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= REQ;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    // Presented word only loads on accept, so it cannot change while out_valid is high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid              <= 1'b0;
            out_inst               <= 32'h0;
            out_orderAddress       <= 40'h0;
            out_branchJumpAddress  <= 40'h0;
            out_branchJumpForecast <= 1'b0;
        end else begin
            if (redirect) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid              <= 1'b1;
                out_inst               <= mem_rdata;
                out_orderAddress       <= seq_pc;
                out_branchJumpAddress  <= pd_isBranch ? pd_target : 40'h0;
                out_branchJumpForecast <= forecast;
            end else if ((state == HOLD) && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Directed bench for fetch_pc_sequencer: sequential fetch, prediction, backpressure,
// redirect priority, PC wrap and asynchronous reset.
module tb_fetch_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic [39:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        pd_isBranch, pd_needPredict, pd_resolvedTaken;
    logic [39:0] pd_target;
    logic        isBranchJmpCode, qequestBranchPrediction;
    logic [39:0] qequestJmpAddress;
    logic        isJmp;
    logic        isRecoverPC;
    logic [39:0] recoverAddress;
    logic        askClean_FetchMod, askInterHandle, askRestartHandle;
    logic        out_valid, out_ready;
    logic [31:0] out_inst;
    logic [39:0] out_orderAddress, out_branchJumpAddress;
    logic        out_branchJumpForecast;

    int n_checks = 0;
    int n_fails  = 0;

    fetch_pc_sequencer dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .pd_isBranch(pd_isBranch), .pd_needPredict(pd_needPredict),
        .pd_resolvedTaken(pd_resolvedTaken), .pd_target(pd_target),
        .isBranchJmpCode(isBranchJmpCode), .qequestBranchPrediction(qequestBranchPrediction),
        .qequestJmpAddress(qequestJmpAddress), .isJmp(isJmp),
        .isRecoverPC(isRecoverPC), .recoverAddress(recoverAddress),
        .askClean_FetchMod(askClean_FetchMod), .askInterHandle(askInterHandle),
        .askRestartHandle(askRestartHandle),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_orderAddress(out_orderAddress), .out_branchJumpAddress(out_branchJumpAddress),
        .out_branchJumpForecast(out_branchJumpForecast)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pd();
        pd_isBranch = 0; pd_needPredict = 0; pd_resolvedTaken = 0;
        pd_target = 40'h0; isJmp = 0;
    endtask

    initial begin
        rst = 0; mem_ack = 0; mem_rdata = 32'h0; out_ready = 0;
        isRecoverPC = 0; recoverAddress = 40'h0;
        askClean_FetchMod = 0; askInterHandle = 0; askRestartHandle = 0;
        clear_pd();
        #3;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_inst", out_inst, 0);
        chk("rst_isBranch", isBranchJmpCode, 0);
        step();
        rst = 1;
        #1;
        chk("post_rst_req", mem_req, 1);
        chk("post_rst_addr", mem_addr, 40'h0);

        // sequential fetch 0x0, 0x4
        mem_ack = 1; out_ready = 1; mem_rdata = 32'h1111_0000;
        step();
        chk("seq0_valid", out_valid, 1);
        chk("seq0_order", out_orderAddress, 40'h4);
        chk("seq0_inst", out_inst, 32'h1111_0000);
        chk("seq0_hold_req", mem_req, 0);
        step();
        chk("seq0_drop", out_valid, 0);
        chk("seq1_addr", mem_addr, 40'h4);
        mem_rdata = 32'h1111_0004;
        step();
        chk("seq1_order", out_orderAddress, 40'h8);
        step();
        chk("seq2_addr", mem_addr, 40'h8);

        // predicted taken at 0x8
        pd_isBranch = 1; pd_needPredict = 1; pd_target = 40'h40; isJmp = 1;
        mem_rdata = 32'h2222_0008;
        #1;
        chk("pt_isB", isBranchJmpCode, 1);
        chk("pt_qreq", qequestBranchPrediction, 1);
        chk("pt_qaddr", qequestJmpAddress, 40'h40);
        step();
        chk("pt_isB_pulse", isBranchJmpCode, 0);
        chk("pt_fc", out_branchJumpForecast, 1);
        chk("pt_bja", out_branchJumpAddress, 40'h40);
        chk("pt_order", out_orderAddress, 40'hC);
        clear_pd();
        step();
        chk("pt_next", mem_addr, 40'h40);

        // resolved not-taken at 0x40; isJmp must be ignored
        pd_isBranch = 1; pd_needPredict = 0; pd_resolvedTaken = 0;
        pd_target = 40'h80; isJmp = 1;
        #1;
        chk("nt_isB", isBranchJmpCode, 1);
        chk("nt_qreq", qequestBranchPrediction, 0);
        step();
        chk("nt_fc", out_branchJumpForecast, 0);
        chk("nt_bja", out_branchJumpAddress, 40'h80);
        clear_pd();
        step();
        chk("nt_next", mem_addr, 40'h44);

        // backpressure at 0x44
        out_ready = 0; mem_rdata = 32'hCAFE_0044;
        step();
        chk("bp_bja_zero", out_branchJumpAddress, 40'h0);
        mem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", out_valid, 1);
            chk("bp_req", mem_req, 0);
            chk("bp_inst", out_inst, 32'hCAFE_0044);
            chk("bp_order", out_orderAddress, 40'h48);
            step();
        end
        out_ready = 1;
        #1;
        chk("bp_valid_last", out_valid, 1);
        step();
        chk("bp_drop", out_valid, 0);
        chk("bp_next", mem_addr, 40'h48);

        // recover and interrupt together in HOLD: interrupt wins
        out_ready = 0;
        step();
        chk("ri_hold", out_valid, 1);
        mem_ack = 0; isRecoverPC = 1; recoverAddress = 40'h200; askInterHandle = 1;
        step();
        isRecoverPC = 0; askInterHandle = 0;
        chk("ri_valid", out_valid, 0);
        chk("ri_req", mem_req, 1);
        chk("ri_addr", mem_addr, 40'h100);

        // recover to wrap address with coincident ack: ack discarded, no predictor update
        isRecoverPC = 1; recoverAddress = 40'hFF_FFFF_FFFC;
        mem_ack = 1; pd_isBranch = 1; pd_target = 40'h500; pd_resolvedTaken = 1;
        #1;
        chk("sup_isB", isBranchJmpCode, 0);
        step();
        isRecoverPC = 0; clear_pd();
        chk("wr_valid", out_valid, 0);
        chk("wr_addr", mem_addr, 40'hFF_FFFF_FFFC);
        out_ready = 1;
        step();
        chk("wr_out_valid", out_valid, 1);
        chk("wr_order", out_orderAddress, 40'h0);
        step();
        chk("wr_next", mem_addr, 40'h0);

        // redirect coincident with handshake: recover PC beats predicted PC
        pd_isBranch = 1; pd_needPredict = 1; pd_target = 40'h40; isJmp = 1;
        step();
        clear_pd();
        chk("rh_hold", out_valid, 1);
        isRecoverPC = 1; recoverAddress = 40'h300;
        step();
        isRecoverPC = 0;
        chk("rh_addr", mem_addr, 40'h300);
        chk("rh_valid", out_valid, 0);

        // clean alone: pc keeps its already-advanced value
        step();
        askClean_FetchMod = 1;
        step();
        askClean_FetchMod = 0;
        chk("cl_valid", out_valid, 0);
        chk("cl_addr", mem_addr, 40'h304);

        // restart from HOLD
        step();
        askRestartHandle = 1;
        step();
        askRestartHandle = 0;
        chk("rs_addr", mem_addr, 40'h0);

        // async reset mid-HOLD
        step();
        step();
        out_ready = 0;
        step();
        chk("ar_hold", out_valid, 1);
        chk("ar_hold_addr", mem_addr, 40'h8);
        #2;
        rst = 0;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_req", mem_req, 0);
        chk("ar_pc", mem_addr, 40'h0);
        chk("ar_inst", out_inst, 0);
        #2;
        rst = 1;
        #1;
        chk("ar_req_after", mem_req, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/fetch_pc_sequencer.md
Name: fetch_pc_sequencer

Overview:
- Instruction-fetch front end, directly upstream of the branch jump predictor.
- Holds the architectural fetch PC, issues single-outstanding fetch requests to the instruction memory port and presents fetched words to the instruction parsing stage.
- Queries the predictor for branches, steers the next PC from the prediction, and redirects on PC-recover, interrupt, restart and pipeline-clean requests.

Parameters:
- RESET_PC, 40'h0, PC loaded on reset and on restart.
- INT_VECTOR, 40'h100, PC loaded on interrupt entry.
- PC_STEP, 4, byte increment between sequential instructions.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- mem_req  out  1  fetch request valid.
- mem_addr  out  40  fetch address.
- mem_ack  in  1  request accepted and mem_rdata valid, same cycle.
- mem_rdata  in  32  fetched instruction word.
- pd_isBranch  in  1  combinational predecode of mem_rdata: branch/jump instruction.
- pd_needPredict  in  1  direction not resolvable at fetch.
- pd_resolvedTaken  in  1  direction when pd_needPredict=0.
- pd_target  in  40  branch target.
- isBranchJmpCode  out  1  to predictor, pulsed on the accept cycle of a branch.
- qequestBranchPrediction  out  1  to predictor, pulsed with isBranchJmpCode when pd_needPredict.
- qequestJmpAddress  out  40  pd_target, qualified by isBranchJmpCode.
- isJmp  in  1  predictor result, sampled the same cycle.
- isRecoverPC  in  1  recover request.
- recoverAddress  in  40  recover target.
- askClean_FetchMod  in  1  flush this stage.
- askInterHandle  in  1  interrupt entry.
- askRestartHandle  in  1  restart.
- out_valid  out  1  instruction valid to parsing stage.
- out_ready  in  1  parsing stage accepts.
- out_inst  out  32  instruction word.
- out_orderAddress  out  40  fall-through address, fetch address + PC_STEP.
- out_branchJumpAddress  out  40  branch target, 0 if not a branch.
- out_branchJumpForecast  out  1  direction used to steer the next PC.

Behaviour:
- Reset (rst=0, async):
  - pc = RESET_PC; state = REQ.
  - mem_req, out_valid, isBranchJmpCode, qequestBranchPrediction = 0.
  - out_* data = 0.
- States:
  - REQ: mem_req=1, mem_addr=pc. On mem_ack, capture word, assert out_valid next cycle, go to HOLD.
  - HOLD: out_valid=1. On out_ready, out_valid drops, go to REQ. The next mem_req is issued the cycle after the handshake.
  - Only one fetch is outstanding at any time. A word is never overwritten while out_valid=1.
- On the mem_ack cycle:
  - isBranchJmpCode = pd_isBranch; qequestBranchPrediction = pd_isBranch & pd_needPredict (combinational).
  - Forecast:
    - pd_needPredict=1: forecast = isJmp.
    - pd_needPredict=0: forecast = pd_resolvedTaken.
    - Non-branch: forecast = 0.
  - Next pc = forecast ? pd_target : pc + PC_STEP, computed modulo 2^40 (wraps at 40'hFF_FFFF_FFFC).
- Redirect priority, highest first; a redirect is effective in the cycle it is asserted, in any state:
  1. askRestartHandle: pc ← RESET_PC.
  2. askInterHandle: pc ← INT_VECTOR.
  3. isRecoverPC: pc ← recoverAddress.
  4. askClean_FetchMod alone: pc unchanged.
- Redirect effects:
  - out_valid → 0 next cycle; state → REQ.
  - The new mem_req is issued the following cycle.
  - isBranchJmpCode is suppressed if mem_ack coincides with a redirect, so the predictor sees no update.
  - A redirect coincident with the out_ready handshake still loads the redirect PC, never the predicted PC.
  - A mem_ack in the redirect cycle is discarded.
- Output data is stable while out_valid=1 and out_ready=0.

Test Plan:
- Sequential fetch:
  - Stimulus: reset, mem_ack and out_ready always 1, non-branch words.
  - Response: mem_addr 0x0, 0x4, 0x8; out_orderAddress 0x4, 0x8, 0xC.
- Predicted taken:
  - Stimulus: word at 0x8 with pd_needPredict=1, pd_target=0x40, isJmp=1.
  - Response: isBranchJmpCode=qequestBranchPrediction=1 for one cycle; out_branchJumpForecast=1; next mem_addr=0x40.
- Resolved not-taken:
  - Stimulus: pd_needPredict=0, pd_resolvedTaken=0.
  - Response: isBranchJmpCode=1, qequestBranchPrediction=0; next mem_addr = pc+4.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles.
  - Response: out_inst/out_orderAddress constant; mem_req=0 throughout; one accepted transfer afterwards.
- Recover vs interrupt:
  - Stimulus: isRecoverPC (recoverAddress=0x200) and askInterHandle in the same cycle during HOLD.
  - Response: out_valid=0 next cycle; next mem_addr=INT_VECTOR (0x100).
- Wrap and async reset:
  - Stimulus: pc=0xFF_FFFF_FFFC, sequential fetch.
  - Response: next mem_addr=0x0.
  - Stimulus: rst low mid-HOLD.
  - Response: out_valid=0 immediately, pc=RESET_PC.
